// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller.
//   - Request mode encodings (MEMREQ_READ / MEMREQ_WRITE)
//   - MMIO base nibble and UART register offsets
//   - Controller FSM state and response-source types
// Optional feature macro: MEM_CTRL_UART_EN adds the UART wait states.
package mem_ctrl_pkg;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  localparam logic [3:0]  MMIO_BASE     = 4'h1;
  localparam logic [27:0] MMIO_RX_OFF   = 28'h000_0000;
  localparam logic [27:0] MMIO_STAT_OFF = 28'h000_0004;
  localparam logic [27:0] MMIO_TX_OFF   = 28'h000_0008;

  typedef enum logic [2:0] {
    StIdle,
    StBramWait,
    StResp
`ifdef MEM_CTRL_UART_EN
    ,
    StRxWait,
    StTxWait
`endif
  } state_e;

  // Where the response data comes from when a fixed-delay wait expires.
  typedef enum logic [1:0] {
    SrcZero,
    SrcBram,
    SrcStatus
  } src_e;

  function automatic logic is_mmio(input logic [31:0] addr);
    return addr[31:28] == MMIO_BASE;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller: turns single-cycle core requests into BRAM accesses or
// UART MMIO accesses and returns a registered one-cycle completion pulse.
// Ports:
//   clk, rstn                         clock, synchronous active-low reset
//   request_enable/mode/addr/wdata/wstrb  core request (pulse, accepted in IDLE)
//   response_enable/data              registered completion pulse and read data
//   bram_en/we/addr/din, bram_dout    BRAM port (dout valid RD_LATENCY after en)
//   uart_rx_valid/data, uart_rx_pop   UART receive side
//   uart_tx_ready, uart_tx_valid/data UART transmit side
// Macro MEM_CTRL_UART_EN enables the UART MMIO registers (RX 0x0, status 0x4,
// TX 0x8). Without it every MMIO access completes at cycle 2 with data 0.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned BRAM_AW    = 16,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               request_enable,
  input  logic               mode,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  input  logic [3:0]         wstrb,
  output logic               response_enable,
  output logic [31:0]        data,
  output logic               bram_en,
  output logic [3:0]         bram_we,
  output logic [BRAM_AW-1:0] bram_addr,
  output logic [31:0]        bram_din,
  input  logic [31:0]        bram_dout,
  input  logic               uart_rx_valid,
  input  logic [7:0]         uart_rx_data,
  output logic               uart_rx_pop,
  input  logic               uart_tx_ready,
  output logic               uart_tx_valid,
  output logic [7:0]         uart_tx_data
);

  localparam logic [2:0] RdCnt = 3'(RD_LATENCY);

  state_e             state_q, state_d;
  src_e               src_q, src_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               resp_en_q, resp_en_d;
  logic [31:0]        data_q, data_d;
  logic               bram_en_q, bram_en_d;
  logic [3:0]         bram_we_q, bram_we_d;
  logic [BRAM_AW-1:0] bram_addr_q, bram_addr_d;
  logic [31:0]        bram_din_q, bram_din_d;
  logic               rx_pop_q, rx_pop_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;

  logic               unused_inputs;
  assign unused_inputs = ^{addr, wdata, uart_rx_data, uart_rx_valid, uart_tx_ready};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      src_q       <= SrcZero;
      cnt_q       <= '0;
      resp_en_q   <= 1'b0;
      data_q      <= '0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= '0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      rx_pop_q    <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      cnt_q       <= cnt_d;
      resp_en_q   <= resp_en_d;
      data_q      <= data_d;
      bram_en_q   <= bram_en_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      rx_pop_q    <= rx_pop_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    cnt_d       = cnt_q;
    resp_en_d   = 1'b0;
    data_d      = data_q;
    bram_en_d   = 1'b0;
    bram_we_d   = '0;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    rx_pop_d    = 1'b0;
    tx_valid_d  = 1'b0;
    tx_data_d   = tx_data_q;

    unique case (state_q)
      StIdle: begin
        if (request_enable) begin
          // StBramWait doubles as the generic fixed-delay wait: when cnt
          // hits zero the response is issued from src on the next edge.
          state_d = StBramWait;
          cnt_d   = '0;
          src_d   = SrcZero;
          if (!is_mmio(addr)) begin
            bram_en_d   = 1'b1;
            bram_addr_d = addr[BRAM_AW+1:2];
            bram_din_d  = wdata;
            if (mode == MEMREQ_WRITE) begin
              bram_we_d = wstrb;
            end else begin
              cnt_d = RdCnt;
              src_d = SrcBram;
            end
          end else begin
`ifdef MEM_CTRL_UART_EN
            if (mode == MEMREQ_READ && addr[27:0] == MMIO_RX_OFF) begin
              state_d = StRxWait;
            end else if (mode == MEMREQ_READ && addr[27:0] == MMIO_STAT_OFF) begin
              src_d = SrcStatus;
            end else if (mode == MEMREQ_WRITE && addr[27:0] == MMIO_TX_OFF) begin
              tx_data_d = wdata[7:0];
              state_d   = StTxWait;
            end
`endif
          end
        end
      end

      StBramWait: begin
        if (cnt_q == '0) begin
          resp_en_d = 1'b1;
          state_d   = StResp;
          case (src_q)
            SrcBram:   data_d = bram_dout;
            SrcStatus: data_d = {30'b0, uart_tx_ready, uart_rx_valid};
            default:   data_d = '0;
          endcase
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

`ifdef MEM_CTRL_UART_EN
      StRxWait: begin
        if (uart_rx_valid) begin
          rx_pop_d  = 1'b1;
          resp_en_d = 1'b1;
          data_d    = {24'b0, uart_rx_data};
          state_d   = StResp;
        end
      end

      StTxWait: begin
        if (uart_tx_ready) begin
          // Pulse the byte out, then respond one cycle later via the wait.
          tx_valid_d = 1'b1;
          cnt_d      = '0;
          src_d      = SrcZero;
          state_d    = StBramWait;
        end
      end
`endif

      StResp: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  assign response_enable = resp_en_q;
  assign data            = data_q;
  assign bram_en         = bram_en_q;
  assign bram_we         = bram_we_q;
  assign bram_addr       = bram_addr_q;
  assign bram_din        = bram_din_q;
  assign uart_rx_pop     = rx_pop_q;
  assign uart_tx_valid   = tx_valid_q;
  assign uart_tx_data    = tx_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl (default parameters). UART expectations
// follow MEM_CTRL_UART_EN when it is defined for the build.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        request_enable = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        response_enable;
  logic [31:0] data;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [15:0] bram_addr;
  logic [31:0] bram_din;
  logic [31:0] bram_dout = '0;
  logic        uart_rx_valid = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_pop;
  logic        uart_tx_ready = 1'b0;
  logic        uart_tx_valid;
  logic [7:0]  uart_tx_data;

  mem_ctrl #(.BRAM_AW(16), .RD_LATENCY(2)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .request_enable (request_enable),
    .mode           (mode),
    .addr           (addr),
    .wdata          (wdata),
    .wstrb          (wstrb),
    .response_enable(response_enable),
    .data           (data),
    .bram_en        (bram_en),
    .bram_we        (bram_we),
    .bram_addr      (bram_addr),
    .bram_din       (bram_din),
    .bram_dout      (bram_dout),
    .uart_rx_valid  (uart_rx_valid),
    .uart_rx_data   (uart_rx_data),
    .uart_rx_pop    (uart_rx_pop),
    .uart_tx_ready  (uart_tx_ready),
    .uart_tx_valid  (uart_tx_valid),
    .uart_tx_data   (uart_tx_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled mid-cycle.
  int          resp_cnt = 0, resp_cyc = 0, pop_cnt = 0, pop_cyc = 0;
  int          txv_cnt = 0, txv_cyc = 0, en_cnt = 0;
  logic [7:0]  tx_byte = '0;
  always @(negedge clk) begin
    if (response_enable) begin resp_cnt++; resp_cyc = cyc; end
    if (uart_rx_pop)     begin pop_cnt++;  pop_cyc = cyc;  end
    if (uart_tx_valid)   begin txv_cnt++;  txv_cyc = cyc; tx_byte = uart_tx_data; end
    if (bram_en) en_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int issue_cyc;
  task automatic issue(input logic m, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws);
    request_enable = 1'b1;
    mode = m; addr = a; wdata = wd; wstrb = ws;
    issue_cyc = cyc;
    step();
    request_enable = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " resp_en"}, 32'(response_enable), 32'd0);
    check({tag, " data"}, data, 32'd0);
    check({tag, " bram_en"}, 32'(bram_en), 32'd0);
    check({tag, " bram_we"}, 32'(bram_we), 32'd0);
    check({tag, " rx_pop"}, 32'(uart_rx_pop), 32'd0);
    check({tag, " tx_valid"}, 32'(uart_tx_valid), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] dout;
    logic        rx_valid;
    logic        tx_ready;
    logic        exp_en;
    logic [3:0]  exp_we;
    logic [15:0] exp_baddr;
    logic [31:0] exp_din;
    int          exp_lat;
    logic [31:0] exp_data;
  } vec_t;

`ifdef MEM_CTRL_UART_EN
  localparam logic [31:0] StatusExp = 32'h0000_0001;
`else
  localparam logic [31:0] StatusExp = 32'h0000_0000;
`endif

  vec_t vecs[8];

  initial begin
    int r0, p0, t0, e0, k;
    vecs[0] = '{"bram_wr_104", 1'b1, 32'h0000_0104, 32'h0000_AB00, 4'b0010, 32'h0, 1'b0, 1'b0,
                1'b1, 4'b0010, 16'h0041, 32'h0000_AB00, 2, 32'h0};
    vecs[1] = '{"bram_rd_104", 1'b0, 32'h0000_0104, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b0, 1'b0,
                1'b1, 4'b0000, 16'h0041, 32'h0, 4, 32'hDEAD_BEEF};
    vecs[2] = '{"bram_rd_top", 1'b0, 32'h0003_FFFC, 32'h0, 4'b1111, 32'h1234_5678, 1'b0, 1'b0,
                1'b1, 4'b0000, 16'hFFFF, 32'h0, 4, 32'h1234_5678};
    vecs[3] = '{"bram_rd_alias", 1'b0, 32'h0004_0008, 32'h0, 4'b0000, 32'h0BAD_CAFE, 1'b0, 1'b0,
                1'b1, 4'b0000, 16'h0002, 32'h0, 4, 32'h0BAD_CAFE};
    vecs[4] = '{"bram_wr_hi", 1'b1, 32'h2000_0010, 32'hCAFE_F00D, 4'b1111, 32'h5555_5555, 1'b0,
                1'b0, 1'b1, 4'b1111, 16'h0004, 32'hCAFE_F00D, 2, 32'h0};
    vecs[5] = '{"mmio_unmapped_rd", 1'b0, 32'h1000_000C, 32'h0, 4'b1111, 32'hFFFF_FFFF, 1'b1,
                1'b1, 1'b0, 4'b0000, 16'h0, 32'h0, 2, 32'h0};
    vecs[6] = '{"mmio_status_wr", 1'b1, 32'h1000_0004, 32'h0000_00FF, 4'b1111, 32'hFFFF_FFFF,
                1'b1, 1'b1, 1'b0, 4'b0000, 16'h0, 32'h0, 2, 32'h0};
    vecs[7] = '{"mmio_status_rd", 1'b0, 32'h1000_0004, 32'h0, 4'b0000, 32'hFFFF_FFFF, 1'b1,
                1'b0, 1'b0, 4'b0000, 16'h0, 32'h0, 2, StatusExp};

    // Reset state.
    repeat (3) step();
    check_reset_outputs("reset");
    rstn = 1'b1;
    step();

    // Table-driven single transactions.
    foreach (vecs[i]) begin
      bram_dout = vecs[i].dout;
      uart_rx_valid = vecs[i].rx_valid;
      uart_tx_ready = vecs[i].tx_ready;
      r0 = resp_cnt; p0 = pop_cnt; t0 = txv_cnt;
      issue(vecs[i].mode, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
      check({vecs[i].name, " c1 bram_en"}, 32'(bram_en), 32'(vecs[i].exp_en));
      check({vecs[i].name, " c1 bram_we"}, 32'(bram_we), 32'(vecs[i].exp_we));
      if (vecs[i].exp_en) begin
        check({vecs[i].name, " c1 bram_addr"}, 32'(bram_addr), 32'(vecs[i].exp_baddr));
        if (vecs[i].mode) check({vecs[i].name, " c1 bram_din"}, bram_din, vecs[i].exp_din);
      end
      step();
      check({vecs[i].name, " c2 bram_en"}, 32'(bram_en), 32'd0);
      repeat (6) step();
      check({vecs[i].name, " resp_count"}, 32'(resp_cnt - r0), 32'd1);
      check({vecs[i].name, " resp_cycle"}, 32'(resp_cyc - issue_cyc), 32'(vecs[i].exp_lat));
      check({vecs[i].name, " data"}, data, vecs[i].exp_data);
      check({vecs[i].name, " no_uart"}, 32'((pop_cnt - p0) + (txv_cnt - t0)), 32'd0);
    end
    uart_rx_valid = 1'b0;
    uart_tx_ready = 1'b0;

    // Second pulse during BRAM_WAIT is ignored.
    bram_dout = 32'h1357_9BDF;
    r0 = resp_cnt; e0 = en_cnt;
    issue(1'b0, 32'h0000_0104, 32'h0, 4'b0);
    step();
    request_enable = 1'b1; mode = 1'b1; addr = 32'h0000_0200; wstrb = 4'hF;
    step();
    request_enable = 1'b0;
    repeat (8) step();
    check("double_req resp_count", 32'(resp_cnt - r0), 32'd1);
    check("double_req bram_en_count", 32'(en_cnt - e0), 32'd1);
    check("double_req resp_cycle", 32'(resp_cyc - issue_cyc), 32'd4);
    check("double_req data", data, 32'h1357_9BDF);

    // RX read, uart_rx_valid rising at cycle 5.
    uart_rx_data = 8'h41;
    r0 = resp_cnt; p0 = pop_cnt;
    issue(1'b0, 32'h1000_0000, 32'h0, 4'b0);
    k = 1;
    while (k < 20 && resp_cnt == r0) begin
      if (k == 5) uart_rx_valid = 1'b1;
      step();
      k++;
      if (uart_rx_pop) uart_rx_valid = 1'b0;
    end
    uart_rx_valid = 1'b0;
    repeat (3) step();
    check("rx resp_count", 32'(resp_cnt - r0), 32'd1);
`ifdef MEM_CTRL_UART_EN
    check("rx pop_count", 32'(pop_cnt - p0), 32'd1);
    check("rx data", data, 32'h0000_0041);
    check("rx resp_after_valid", 32'(resp_cyc - issue_cyc > 5), 32'd1);
`else
    check("rx pop_count", 32'(pop_cnt - p0), 32'd0);
    check("rx data", data, 32'h0);
    check("rx resp_cycle", 32'(resp_cyc - issue_cyc), 32'd2);
`endif

    // TX write with uart_tx_ready low for the first 3 cycles.
    r0 = resp_cnt; t0 = txv_cnt; e0 = en_cnt;
    issue(1'b1, 32'h1000_0008, 32'h0000_005A, 4'hF);
    step(); step();
    uart_tx_ready = 1'b1;
    repeat (8) step();
    uart_tx_ready = 1'b0;
    check("tx resp_count", 32'(resp_cnt - r0), 32'd1);
    check("tx no_bram", 32'(en_cnt - e0), 32'd0);
    check("tx data", data, 32'h0);
`ifdef MEM_CTRL_UART_EN
    check("tx valid_count", 32'(txv_cnt - t0), 32'd1);
    check("tx byte", 32'(tx_byte), 32'h5A);
    check("tx valid_after_ready", 32'(txv_cyc - issue_cyc > 3), 32'd1);
    check("tx resp_next", 32'(resp_cyc - txv_cyc), 32'd1);
`else
    check("tx valid_count", 32'(txv_cnt - t0), 32'd0);
    check("tx resp_cycle", 32'(resp_cyc - issue_cyc), 32'd2);
`endif

    // Reset while a request is in flight (RX_WAIT when UART is present).
    r0 = resp_cnt;
`ifdef MEM_CTRL_UART_EN
    issue(1'b0, 32'h1000_0000, 32'h0, 4'b0);
`else
    issue(1'b0, 32'h0000_0104, 32'h0, 4'b0);
`endif
    step();
    rstn = 1'b0;
    step(); step();
    check_reset_outputs("midreset");
    rstn = 1'b1;
    uart_rx_valid = 1'b1;
    repeat (5) step();
    uart_rx_valid = 1'b0;
    check("midreset no_resp", 32'(resp_cnt - r0), 32'd0);
    bram_dout = 32'hA5A5_5A5A;
    r0 = resp_cnt;
    issue(1'b0, 32'h0000_0104, 32'h0, 4'b0);
    check("post_reset bram_en", 32'(bram_en), 32'd1);
    repeat (7) step();
    check("post_reset resp_count", 32'(resp_cnt - r0), 32'd1);
    check("post_reset resp_cycle", 32'(resp_cyc - issue_cyc), 32'd4);
    check("post_reset data", data, 32'hA5A5_5A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
